// File: rtl/ssp_rx_fifo.sv
// ssp_rx_fifo: receive-side word buffer for the SSP peripheral.
// Words strobed in from the serial receive shifter are held in a circular
// store and handed back in arrival order to the APB read path. Provides a
// fill level, empty/full status, a programmable interrupt threshold and a
// sticky overrun flag for words dropped while the buffer was full.
module ssp_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2
) (
  input  logic              pclk,
  input  logic              clear_b,
  input  logic              psel,
  input  logic              pwrite,
  input  logic              rcv,
  input  logic [DWIDTH-1:0] rxdata,
  input  logic [AWIDTH:0]   thresh,
  input  logic              ovr_clr,
  output logic [DWIDTH-1:0] prdata,
  output logic [AWIDTH:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              ssprxintr
);

  localparam int            DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);

  // Storage and state.
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wp;
  logic [AWIDTH-1:0] r_rp;
  logic [AWIDTH:0]   r_level;
  logic [DWIDTH-1:0] r_prdata;
  logic              r_overrun;

  // Decoded per-cycle operations.
  logic              w_empty;
  logic              w_full;
  logic              w_rd_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AWIDTH:0]   w_level_nxt;
  logic              w_thresh_hit;

  // Status comes only from registered level, so it cannot glitch on bus inputs.
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == DEPTH_L);

  // A read request always updates prdata; it only consumes a word when one exists.
  assign w_rd_req = psel & ~pwrite;
  assign w_pop    = w_rd_req & ~w_empty;

  // When full, an incoming word is still accepted if a pop frees a slot this cycle.
  assign w_push   = rcv & (~w_full | w_pop);
  assign w_drop   = rcv & w_full & ~w_pop;

  // Next fill level: push and pop in the same cycle cancel out.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (AWIDTH + 1)'(1);
      2'b01:   w_level_nxt = r_level - (AWIDTH + 1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Word store: written at the write pointer on every accepted push.
  // NOTE: the data array is deliberately left out of reset; pointers and level
  // alone define which entries are valid, so clearing it would only cost logic.
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wp] <= rxdata;
    end
  end

  // Pointers and fill level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AWIDTH'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AWIDTH'(1);
      end
      r_level <= w_level_nxt;
    end
  end

  // Registered read data: head word on a pop, zero on a read of an empty
  // buffer (no bypass of a word arriving the same cycle), held otherwise.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_prdata <= '0;
    end else if (w_rd_req) begin
      r_prdata <= w_pop ? r_mem[r_rp] : '0;
    end
  end

  // Sticky overrun: a dropped word sets it and takes priority over the clear.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // A zero threshold disables the level term; one above DEPTH can never be reached.
  assign w_thresh_hit = (thresh != '0) && (r_level >= thresh);

  assign prdata    = r_prdata;
  assign level     = r_level;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overrun   = r_overrun;
  assign ssprxintr = r_overrun | w_thresh_hit;

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// tb_ssp_rx_fifo: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the receive buffer.
module tb_ssp_rx_fifo;

  localparam int DWIDTH = 8;
  localparam int AWIDTH = 2;
  localparam int DEPTH  = 2 ** AWIDTH;

  logic              pclk;
  logic              clear_b;
  logic              psel;
  logic              pwrite;
  logic              rcv;
  logic [DWIDTH-1:0] rxdata;
  logic [AWIDTH:0]   thresh;
  logic              ovr_clr;
  logic [DWIDTH-1:0] prdata;
  logic [AWIDTH:0]   level;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              ssprxintr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DWIDTH-1:0] m_q[$];
  logic [DWIDTH-1:0] m_prdata;
  logic              m_ovr;

  ssp_rx_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .pclk      (pclk),
    .clear_b   (clear_b),
    .psel      (psel),
    .pwrite    (pwrite),
    .rcv       (rcv),
    .rxdata    (rxdata),
    .thresh    (thresh),
    .ovr_clr   (ovr_clr),
    .prdata    (prdata),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overrun   (overrun),
    .ssprxintr (ssprxintr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all(input string tag);
    int  lvl;
    logic intr;
    lvl  = m_q.size();
    intr = m_ovr || ((thresh != 0) && (lvl >= int'(thresh)));
    check({tag, ".prdata"},  32'(prdata),    32'(m_prdata));
    check({tag, ".level"},   32'(level),     32'(lvl));
    check({tag, ".empty"},   32'(empty),     32'(lvl == 0));
    check({tag, ".full"},    32'(full),      32'(lvl == DEPTH));
    check({tag, ".overrun"}, 32'(overrun),   32'(m_ovr));
    check({tag, ".intr"},    32'(ssprxintr), 32'(intr));
  endtask

  // One clock edge: apply the rules to the inputs held across the edge,
  // then compare outputs just after the edge.
  task automatic step(input string tag);
    bit rd, can_pop, was_full;
    @(posedge pclk);
    rd       = psel && !pwrite;
    can_pop  = rd && (m_q.size() != 0);
    was_full = (m_q.size() == DEPTH);
    if (rd) m_prdata = can_pop ? m_q.pop_front() : '0;
    if (rcv) begin
      if (!was_full || can_pop) m_q.push_back(rxdata);
    end
    if (rcv && was_full && !can_pop) m_ovr = 1'b1;
    else if (ovr_clr)                m_ovr = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit r, input logic [DWIDTH-1:0] d, input bit sel,
                       input bit wr, input bit oc);
    rcv     = r;
    rxdata  = d;
    psel    = sel;
    pwrite  = wr;
    ovr_clr = oc;
  endtask

  task automatic push(input logic [DWIDTH-1:0] d, input string tag);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    step(tag);
  endtask

  task automatic pop(input string tag);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prdata = '0;
    m_ovr    = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic apply_reset(input string tag);
    @(negedge pclk);
    #2;
    clear_b = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge pclk);
    clear_b = 1'b1;
  endtask

  initial begin
    clear_b = 1'b1;
    thresh  = '0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    apply_reset("por");

    // Reset with stored words discards them.
    push(8'h01, "rst_fill"); push(8'h02, "rst_fill"); push(8'h03, "rst_fill");
    pop("rst_pop");
    push(8'h04, "rst_fill");
    check("rst_level_pre", 32'(level), 32'd3);
    apply_reset("rst_mid");
    idle("rst_after");

    // Ordering and pointer wrap.
    push(8'h11, "ord"); push(8'h22, "ord"); push(8'h33, "ord");
    pop("ord_pop"); pop("ord_pop");
    push(8'h44, "wrap"); push(8'h55, "wrap"); push(8'h66, "wrap");
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) pop("wrap_pop");
    check("wrap_last", 32'(prdata), 32'h66);
    check("wrap_empty", 32'(empty), 32'd1);

    // Threshold.
    thresh = 3'd3;
    push(8'h01, "thr"); push(8'h02, "thr");
    check("thr_low", 32'(ssprxintr), 32'd0);
    push(8'h03, "thr");
    check("thr_hit", 32'(ssprxintr), 32'd1);
    pop("thr_pop");
    check("thr_drop", 32'(ssprxintr), 32'd0);
    push(8'h04, "thr"); push(8'h05, "thr");
    thresh = 3'd0;
    idle("thr_off");
    check("thr_off_full", 32'(ssprxintr), 32'd0);
    thresh = 3'd5;
    idle("thr_above");
    for (int i = 0; i < 4; i++) pop("thr_drain");

    // Overrun.
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), "ovr_fill");
    push(8'hFF, "ovr_drop");
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) pop("ovr_pop");
    check("ovr_last", 32'(prdata), 32'hA3);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("ovr_clr");
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Drop and clear together: set wins.
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), "ovr2_fill");
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    step("ovr_set_wins");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("ovr2_clr");
    for (int i = 0; i < 4; i++) pop("ovr2_drain");

    // Simultaneous push and pop at full.
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), "sim_fill");
    drive(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
    step("sim_both");
    check("sim_head", 32'(prdata), 32'hA0);
    for (int i = 0; i < 4; i++) pop("sim_drain");
    check("sim_last", 32'(prdata), 32'hB0);

    // Reads while empty, with and without a concurrent arrival.
    pop("empty_rd");
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    step("empty_rd_rcv");
    check("empty_rcv_lvl", 32'(level), 32'd1);
    pop("empty_next");
    check("empty_next_data", 32'(prdata), 32'h5A);

    // Write cycles do not pop.
    push(8'h77, "wr_fill");
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step("wr_nopop");
    pop("wr_pop");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      thresh = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 99) < 55), 8'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 15),
            1'($urandom_range(0, 99) < 5));
      step("rnd");
      if ($urandom_range(0, 999) == 0) apply_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssp_rx_fifo.md
# ssp_rx_fifo

Parametrised receive FIFO for the SSP peripheral: buffers words arriving from the serial receive shifter and returns them in order to the APB-side read path. It generalises the fixed 4x8 receive buffer with configurable width and depth, a circular (non-shifting) store, a programmable interrupt threshold, level/full/empty status and a sticky overrun flag. It sits between the SSP receive shifter (`rcv`/`rxdata`) and the APB register decode (`psel`/`pwrite`/`prdata`).

## Interface
- DWIDTH, 8: data word width in bits.
- AWIDTH, 2: pointer width; DEPTH = 2**AWIDTH entries (AWIDTH >= 1).
- pclk  input  1  single clock; all state changes on rising edge.
- clear_b  input  1  reset; asynchronous and active-low.
- psel  input  1  APB select; with pwrite low, requests one pop this cycle.
- pwrite  input  1  APB write strobe; pop occurs only when low.
- rcv  input  1  one-cycle strobe: rxdata holds a received word.
- rxdata  input  DWIDTH  received word, sampled when rcv high.
- thresh  input  AWIDTH+1  interrupt threshold level; 0 disables threshold term.
- ovr_clr  input  1  synchronous clear of overrun flag.
- prdata  output  DWIDTH  registered read data.
- level  output  AWIDTH+1  number of stored words, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- overrun  output  1  sticky: a word was dropped.
- ssprxintr  output  1  receive interrupt.

## Operation
- Storage: DEPTH x DWIDTH array, write pointer wp and read pointer rp (AWIDTH bits each, wrap modulo DEPTH), counter level (AWIDTH+1 bits). No data shifting.
- pop = psel & ~pwrite & ~empty. push = rcv & (~full | pop).
- Push: mem[wp] <= rxdata; wp <= wp+1.
- Pop: prdata <= mem[rp]; rp <= rp+1.
- Read request while empty: prdata <= 0; pointers, level unchanged; no error flag.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full and simultaneous rcv+pop: both accepted; pop returns old head, new word written into the freed slot; level stays DEPTH.
- Empty and simultaneous rcv+read: push accepted, read returns 0 (no bypass); level becomes 1.
- Overrun: rcv & full & ~pop -> word dropped, overrun <= 1. Sticky until ovr_clr high at a clock edge; if drop and ovr_clr coincide, set wins.
- prdata holds its value between pops.
- ssprxintr = overrun | (thresh != 0 & level >= thresh); thresh > DEPTH makes threshold term never fire.
- empty, full, ssprxintr decoded combinationally from registered level/overrun (glitch-free w.r.t. inputs other than thresh).

## Timing
- Reset (clear_b low, asynchronous, immediate): wp=rp=0, level=0, prdata=0, overrun=0 -> empty=1, full=0, ssprxintr=0. Array contents need not be cleared. Release is synchronous to next pclk edge; assertion mid-transfer discards all stored data.
- rcv/psel/pwrite/ovr_clr/thresh sampled at rising edge of pclk; single-cycle operations, back-to-back every cycle permitted.
- Push latency: level/empty/full/ssprxintr update after the edge sampling rcv; word poppable in the next cycle.
- Pop latency: prdata valid after the edge sampling psel & ~pwrite; each cycle of held psel & ~pwrite pops another word (bus side must pulse for one word).
- Overrun visible on overrun/ssprxintr after the dropping edge.

## Test plan
- Reset: drive clear_b low mid-cycle with FIFO holding 3 words -> immediately level=0, empty=1, prdata=0, overrun=0, ssprxintr=0.
- Ordering and wrap: DWIDTH=8, AWIDTH=2; push 0x11,0x22,0x33, pop 2, push 0x44,0x55,0x66 -> full=1, level=4; pop 4 -> prdata 0x33,0x44,0x55,0x66, then empty=1.
- Threshold: thresh=3; push 2 -> ssprxintr=0; 3rd push -> ssprxintr=1 next cycle; one pop -> 0. thresh=0 with full FIFO -> ssprxintr=0.
- Overrun: fill 0xA0..0xA3, rcv 0xFF -> overrun=1, ssprxintr=1, level=4; pop 4 -> 0xA0..0xA3 (0xFF absent); ovr_clr pulse -> overrun=0.
- Simultaneous at full: full with 0xA0..0xA3, rcv 0xB0 + pop same cycle -> prdata=0xA0, level=4, overrun=0; drain -> 0xA1,0xA2,0xA3,0xB0.
- Empty read: read when empty -> prdata=0, level=0; concurrent rcv 0x5A + read on empty -> prdata=0, level=1, next pop returns 0x5A.
